// File: rtl/mux_n_pipe.sv
// mux_n_pipe: registered N:1 channel mux with valid/ready handshaking.
//
// Selects one of NUM_IN WIDTH-bit input channels and captures the chosen word
// into a one-entry output register. The channel is picked in one of two ways:
//   ARB_MODE = 0 : explicit channel index on 'select'
//   ARB_MODE = 1 : round-robin among channels with in_valid set ('select' ignored)
// A held word can be replaced on the same edge it is consumed, so the block
// sustains one word per cycle.
//
// Parameters:
//   WIDTH    data width per channel
//   NUM_IN   number of input channels (2..16)
//   SEL_W    index width, must equal clog2(NUM_IN)
//   ARB_MODE 0 = explicit select, 1 = round-robin
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset      synchronous active-high reset
//   in_data    flattened channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (combinational, at most one bit set)
//   select     channel index (ARB_MODE = 0 only)
//   out_data   registered selected word
//   out_src    registered index of the channel that supplied out_data
//   out_valid  out_data holds an unconsumed word
//   out_ready  downstream accepts out_data this cycle

module mux_n_pipe #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned NUM_IN   = 4,
    parameter int unsigned SEL_W    = 2,
    parameter int unsigned ARB_MODE = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [SEL_W-1:0]        select,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_src,
    output logic                    out_valid,
    input  logic                    out_ready
);

    // Output register and round-robin pointer.
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_src_q, out_src_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] rr_last_q, rr_last_d;

    // Grant decode.
    logic              grant_vld;
    logic [SEL_W-1:0]  grant_idx;
    logic [NUM_IN-1:0] grant_oh;
    logic [WIDTH-1:0]  grant_data;
    int unsigned       rr_dist;
    int unsigned       rr_best;

    logic load_en;
    logic xfer;

    // The output register may take a new word when empty or being drained.
    assign load_en = !out_valid_q || out_ready;

    // Grant selection. Explicit mode decodes the index directly; out-of-range
    // select values (possible when NUM_IN is not a power of two) match no
    // channel and therefore produce no grant.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        rr_dist   = 0;
        rr_best   = NUM_IN;
        if (ARB_MODE == 0) begin
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                if (32'(select) == i) begin
                    grant_vld   = 1'b1;
                    grant_idx   = SEL_W'(i);
                    grant_oh[i] = 1'b1;
                end
            end
        end else begin
            // Round-robin: rank each valid channel by its distance past
            // rr_last (rr_last+1 ranks 0) and keep the closest. The distance
            // wraps at NUM_IN, not at 2^SEL_W.
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                if (in_valid[i]) begin
                    rr_dist = i + NUM_IN - 1 - 32'(rr_last_q);
                    if (rr_dist >= NUM_IN) begin
                        rr_dist = rr_dist - NUM_IN;
                    end
                    if (rr_dist < rr_best) begin
                        rr_best   = rr_dist;
                        grant_vld = 1'b1;
                        grant_idx = SEL_W'(i);
                    end
                end
            end
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                grant_oh[i] = grant_vld && (grant_idx == SEL_W'(i));
            end
        end
    end

    // Data mux driven by the one-hot grant.
    always_comb begin
        grant_data = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (grant_oh[i]) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // No ready during reset: anything offered that cycle would be lost.
    assign in_ready = (load_en && !reset) ? grant_oh : '0;
    assign xfer     = |(in_ready & in_valid);

    // Next-state logic.
    always_comb begin
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_valid_d = out_valid_q;
        rr_last_d   = rr_last_q;
        if (xfer) begin
            out_data_d  = grant_data;
            out_src_d   = grant_idx;
            out_valid_d = 1'b1;
            if (ARB_MODE != 0) begin
                rr_last_d = grant_idx;
            end
        end else if (load_en) begin
            // Drained (or already empty) with nothing new: data/src keep
            // their last value, only valid drops.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_valid_q <= 1'b0;
            // Pointer at the last channel so channel 0 has first priority.
            rr_last_q   <= SEL_W'(NUM_IN - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_valid_q <= out_valid_d;
            rr_last_q   <= rr_last_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_n_pipe.sv
// Testbench for mux_n_pipe: four instances (explicit/round-robin x 4/3 channels)
// driven each cycle, with a scoreboard queue per instance filled from a
// behavioural model and drained by a separate output monitor.

module tb_mux_n_pipe;

    typedef struct packed {
        logic [1:0]  src;
        logic [31:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [127:0] in_data [4];
    logic [3:0]   in_valid [4];
    logic [1:0]   sel [4];
    logic         ordy [4];

    logic [3:0]  rdy0, rdy1;
    logic [2:0]  rdy2, rdy3;
    logic [31:0] od0, od1, od2, od3;
    logic [1:0]  os0, os1, os2, os3;
    logic        ov0, ov1, ov2, ov3;

    exp_t q0[$], q1[$], q2[$], q3[$];
    int   rr [4];
    int   total = 0;
    int   bad = 0;
    bit   armed = 1'b0;
    bit   prev_reset = 1'b0;

    always #5 clk = ~clk;

    mux_n_pipe #(.WIDTH(32), .NUM_IN(4), .SEL_W(2), .ARB_MODE(0)) u_d0 (
        .clk(clk), .reset(reset), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(rdy0), .select(sel[0]), .out_data(od0), .out_src(os0),
        .out_valid(ov0), .out_ready(ordy[0]));
    mux_n_pipe #(.WIDTH(32), .NUM_IN(4), .SEL_W(2), .ARB_MODE(1)) u_d1 (
        .clk(clk), .reset(reset), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(rdy1), .select(sel[1]), .out_data(od1), .out_src(os1),
        .out_valid(ov1), .out_ready(ordy[1]));
    mux_n_pipe #(.WIDTH(32), .NUM_IN(3), .SEL_W(2), .ARB_MODE(0)) u_d2 (
        .clk(clk), .reset(reset), .in_data(in_data[2][95:0]), .in_valid(in_valid[2][2:0]),
        .in_ready(rdy2), .select(sel[2]), .out_data(od2), .out_src(os2),
        .out_valid(ov2), .out_ready(ordy[2]));
    mux_n_pipe #(.WIDTH(32), .NUM_IN(3), .SEL_W(2), .ARB_MODE(1)) u_d3 (
        .clk(clk), .reset(reset), .in_data(in_data[3][95:0]), .in_valid(in_valid[3][2:0]),
        .in_ready(rdy3), .select(sel[3]), .out_data(od3), .out_src(os3),
        .out_valid(ov3), .out_ready(ordy[3]));

    function automatic int nin_of(int k);
        return (k < 2) ? 4 : 3;
    endfunction

    function automatic int mode_of(int k);
        return k % 2;
    endfunction

    function automatic logic [3:0] get_rdy(int k);
        case (k)
            0: return rdy0;
            1: return rdy1;
            2: return {1'b0, rdy2};
            default: return {1'b0, rdy3};
        endcase
    endfunction

    function automatic logic [31:0] get_od(int k);
        case (k)
            0: return od0;
            1: return od1;
            2: return od2;
            default: return od3;
        endcase
    endfunction

    function automatic logic [1:0] get_os(int k);
        case (k)
            0: return os0;
            1: return os1;
            2: return os2;
            default: return os3;
        endcase
    endfunction

    function automatic logic get_ov(int k);
        case (k)
            0: return ov0;
            1: return ov1;
            2: return ov2;
            default: return ov3;
        endcase
    endfunction

    function automatic int qsize(int k);
        case (k)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return q3.size();
        endcase
    endfunction

    task automatic qpush(input int k, input exp_t e);
        case (k)
            0: q0.push_back(e);
            1: q1.push_back(e);
            2: q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endtask

    task automatic qpop(input int k, output exp_t e);
        case (k)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            2: e = q2.pop_front();
            default: e = q3.pop_front();
        endcase
    endtask

    task automatic qclear(input int k);
        case (k)
            0: q0.delete();
            1: q1.delete();
            2: q2.delete();
            default: q3.delete();
        endcase
    endtask

    task automatic chk(input string nm, input int k, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d t=%0t actual=%0h required=%0h", nm, k, $time, act, exp);
        end
    endtask

    // Reference arbitration: explicit index if in range, otherwise the first
    // valid channel after the last winner, wrapping at the channel count.
    function automatic int model_grant(int k);
        int n;
        n = nin_of(k);
        if (mode_of(k) == 0) begin
            return (int'(sel[k]) < n) ? int'(sel[k]) : -1;
        end
        for (int j = 1; j <= n; j++) begin
            int c;
            c = (rr[k] + j) % n;
            if (in_valid[k][c]) return c;
        end
        return -1;
    endfunction

    // One clock cycle: inputs were applied at the falling edge; predict the
    // ready pattern and any accepted word, then move to the next falling edge.
    task automatic cyc();
        #2;
        for (int k = 0; k < 4; k++) begin
            bit         held;
            bit         ld;
            int         g;
            logic [3:0] exp_rdy;
            exp_t       e;
            held    = (qsize(k) != 0);
            ld      = !held || ordy[k];
            g       = model_grant(k);
            exp_rdy = 4'b0000;
            if (!reset && ld && g >= 0) exp_rdy[g] = 1'b1;
            chk("in_ready", k, get_rdy(k), exp_rdy);
            if (prev_reset) begin
                chk("rst_out_data", k, get_od(k), 0);
                chk("rst_out_src", k, get_os(k), 0);
            end
            if (reset) begin
                qclear(k);
                rr[k] = nin_of(k) - 1;
            end else if (exp_rdy != 0 && in_valid[k][g]) begin
                e.src  = g[1:0];
                e.data = in_data[k][g*32 +: 32];
                qpush(k, e);
                if (mode_of(k) == 1) rr[k] = g;
            end
        end
        prev_reset = reset;
        @(negedge clk);
        armed = 1'b1;
    endtask

    task automatic set_all(input logic rst, input logic [3:0] v, input logic [1:0] s,
                           input logic r);
        reset = rst;
        for (int k = 0; k < 4; k++) begin
            in_valid[k] = (nin_of(k) == 4) ? v : (v & 4'b0111);
            sel[k]      = s;
            ordy[k]     = r;
        end
    endtask

    task automatic set_ch(input int i, input logic [31:0] d);
        for (int k = 0; k < 4; k++) in_data[k][i*32 +: 32] = d;
    endtask

    // Monitor: every cycle the DUT must present a word exactly when the
    // scoreboard holds one, and a consumed word must match the oldest entry.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (armed) begin
                for (int k = 0; k < 4; k++) begin
                    logic v;
                    exp_t e;
                    v = get_ov(k);
                    chk("out_valid", k, v, qsize(k) != 0);
                    if (v && ordy[k] && qsize(k) != 0) begin
                        qpop(k, e);
                        chk("out_data", k, get_od(k), e.data);
                        chk("out_src", k, get_os(k), e.src);
                    end
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < 4; k++) begin
            in_data[k] = '0;
            rr[k]      = nin_of(k) - 1;
        end
        set_all(1'b1, 4'b0000, 2'd0, 1'b0);
        @(negedge clk);
        cyc();
        cyc();

        // Explicit select, then stall with ch1 waiting, then release.
        set_ch(2, 32'd55);
        set_all(1'b0, 4'b0100, 2'd2, 1'b1);
        cyc();
        set_ch(1, 32'd77);
        set_all(1'b0, 4'b0010, 2'd1, 1'b0);
        repeat (3) cyc();
        set_all(1'b0, 4'b0010, 2'd1, 1'b1);
        cyc();
        set_ch(0, 32'd10);
        set_all(1'b0, 4'b0001, 2'd0, 1'b1);
        cyc();

        // Hold a word, then reset on top of it.
        set_all(1'b0, 4'b0001, 2'd0, 1'b0);
        cyc();
        set_all(1'b1, 4'b1111, 2'd0, 1'b0);
        cyc();
        set_all(1'b0, 4'b0000, 2'd0, 1'b1);
        cyc();

        // All channels valid: round-robin walks the channels and wraps.
        for (int i = 0; i < 4; i++) set_ch(i, 32'(100 + i));
        for (int i = 0; i < 6; i++) begin
            set_all(1'b0, 4'b1111, 2'(i), 1'b1);
            cyc();
        end

        // Sparse valids with idle gaps that must not move the pointer.
        set_all(1'b0, 4'b1010, 2'd1, 1'b1);
        repeat (3) cyc();
        set_all(1'b0, 4'b0000, 2'd1, 1'b1);
        repeat (2) cyc();
        set_all(1'b0, 4'b1010, 2'd3, 1'b1);
        repeat (2) cyc();

        // select=3: legal on 4 channels, no grant on 3 channels.
        set_all(1'b0, 4'b1111, 2'd3, 1'b1);
        repeat (3) cyc();

        // Randomised traffic with backpressure and occasional resets.
        for (int n = 0; n < 600; n++) begin
            reset = (($urandom % 64) == 0);
            for (int k = 0; k < 4; k++) begin
                in_data[k]  = {$urandom, $urandom, $urandom, $urandom};
                in_valid[k] = 4'($urandom) & ((nin_of(k) == 4) ? 4'b1111 : 4'b0111);
                sel[k]      = 2'($urandom);
                ordy[k]     = (($urandom % 4) != 0);
            end
            cyc();
        end

        set_all(1'b0, 4'b0000, 2'd0, 1'b1);
        repeat (3) cyc();
        for (int k = 0; k < 4; k++) chk("drained", k, qsize(k), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
